// File: rtl/negate_serial_if.sv
// negate_serial_if: start/busy/done handshake and data bus between control unit and negate_serial
interface negate_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] Ra;
  logic [WIDTH-1:0] Rz;
  logic             busy;
  logic             done;
  logic             ovf;
  modport master (output start, mode, Ra, input Rz, busy, done, ovf);
  modport slave  (input start, mode, Ra, output Rz, busy, done, ovf);
endinterface

// File: rtl/negate_serial.sv
// negate_serial: slice-serial two's-complement pass/negate/abs/neg-abs unit with overflow flag
module negate_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic            clk,
  input logic            clr_n,
  negate_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int SW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d, res_q, res_d, rz_q, rz_d, res_n;
  logic [SW-1:0]    slice_q, slice_d;
  logic             inv_q, inv_d, carry_q, carry_d, mn_q, mn_d, ovf_q, ovf_d;
  logic [CHUNK:0]   sum;
  logic             go, run, last, inv_n;
  // Slice adder, handshake decode and next-state selection
  always_comb begin
    sum = {1'b0, op_q[CHUNK-1:0] ^ {CHUNK{inv_q}}} + (CHUNK+1)'(carry_q);
    res_n = (res_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    run = state_q == RUN;
    go = bus.start & ~run;
    last = slice_q == SW'(NSLICE - 1);
    inv_n = (bus.mode == 2'b01) | (bus.mode == 2'b10 & bus.Ra[WIDTH-1]) | (bus.mode == 2'b11 & ~bus.Ra[WIDTH-1]);
    state_d = go ? RUN : run ? (last ? DONE : RUN) : IDLE;
    op_d = go ? bus.Ra : run ? op_q >> CHUNK : op_q;
    res_d = run ? res_n : res_q;
    inv_d = go ? inv_n : inv_q;
    carry_d = go ? inv_n : run ? sum[CHUNK] : carry_q;
    slice_d = go ? '0 : run ? SW'(slice_q + 1'b1) : slice_q;
    mn_d = go ? inv_n & (bus.Ra == MN) : mn_q;
    rz_d = run & last ? res_n : rz_q;
    ovf_d = run & last ? mn_q : ovf_q;
  end
  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      rz_q    <= '0;
      slice_q <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      mn_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rz_q    <= rz_d;
      slice_q <= slice_d;
      inv_q   <= inv_d;
      carry_q <= carry_d;
      mn_q    <= mn_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.Rz   = rz_q;
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_negate_serial.sv
// tb_negate_serial: directed self-checking bench for negate_serial (CHUNK 8 and CHUNK 32 instances)
module tb_negate_serial;
  logic clk = 0;
  logic clr_n = 0;
  int pass_cnt = 0;
  int total = 0;
  negate_serial_if #(.WIDTH(32)) b0 ();
  negate_serial_if #(.WIDTH(32)) b1 ();
  negate_serial #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .clr_n(clr_n), .bus(b0.slave));
  negate_serial #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .clr_n(clr_n), .bus(b1.slave));
  always #5 clk = ~clk;

  task automatic do_op(input logic [1:0] m, input logic [31:0] a, output int lat, output int bc);
    @(negedge clk); b0.start = 1; b0.mode = m; b0.Ra = a;
    @(posedge clk); #1; b0.start = 0; b0.Ra = ~a; b0.mode = ~m;
    lat = 0; bc = b0.busy ? 1 : 0;
    while (!b0.done && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (b0.busy) bc++;
    end
  endtask

  task automatic test_reset;
    b0.start = 1; b0.mode = 2'b01; b0.Ra = 32'h1; b1.start = 0; b1.mode = 0; b1.Ra = 0; clr_n = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (b0.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b0.busy); else pass_cnt++;
    total++; if (b0.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", b0.done); else pass_cnt++;
    total++; if (b0.Rz !== 32'h0) $display("FAIL reset_rz got=%h exp=00000000", b0.Rz); else pass_cnt++;
    total++; if (b0.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", b0.ovf); else pass_cnt++;
    b0.start = 0; clr_n = 1;
  endtask

  task automatic test_negate;
    int lat, bc;
    do_op(2'b01, 32'hAAAAAAAA, lat, bc);
    total++; if (lat !== 4) $display("FAIL neg_latency got=%0d exp=4", lat); else pass_cnt++;
    total++; if (bc !== 4) $display("FAIL neg_busy_cycles got=%0d exp=4", bc); else pass_cnt++;
    total++; if (b0.Rz !== 32'h55555556) $display("FAIL neg_aaaa got=%h exp=55555556", b0.Rz); else pass_cnt++;
    total++; if (b0.ovf !== 1'b0) $display("FAIL neg_aaaa_ovf got=%b exp=0", b0.ovf); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (b0.done !== 1'b0) $display("FAIL done_pulse got=%b exp=0", b0.done); else pass_cnt++;
    do_op(2'b01, 32'h0, lat, bc);
    total++; if (b0.Rz !== 32'h0 || b0.ovf !== 1'b0) $display("FAIL neg_zero got=%h/%b exp=00000000/0", b0.Rz, b0.ovf); else pass_cnt++;
    do_op(2'b01, 32'hFFFFFFFF, lat, bc);
    total++; if (b0.Rz !== 32'h1) $display("FAIL neg_ones got=%h exp=00000001", b0.Rz); else pass_cnt++;
    do_op(2'b01, 32'h80000000, lat, bc);
    total++; if (b0.Rz !== 32'h80000000 || b0.ovf !== 1'b1) $display("FAIL neg_mn got=%h/%b exp=80000000/1", b0.Rz, b0.ovf); else pass_cnt++;
  endtask

  task automatic test_modes;
    int lat, bc;
    do_op(2'b10, 32'hFFFFFFF6, lat, bc);
    total++; if (b0.Rz !== 32'h0000000A || b0.ovf !== 1'b0) $display("FAIL abs_neg got=%h/%b exp=0000000a/0", b0.Rz, b0.ovf); else pass_cnt++;
    do_op(2'b10, 32'h7, lat, bc);
    total++; if (b0.Rz !== 32'h7) $display("FAIL abs_pos got=%h exp=00000007", b0.Rz); else pass_cnt++;
    do_op(2'b10, 32'h80000000, lat, bc);
    total++; if (b0.Rz !== 32'h80000000 || b0.ovf !== 1'b1) $display("FAIL abs_mn got=%h/%b exp=80000000/1", b0.Rz, b0.ovf); else pass_cnt++;
    repeat (3) @(posedge clk); #1;
    total++; if (b0.Rz !== 32'h80000000 || b0.ovf !== 1'b1) $display("FAIL hold_idle got=%h/%b exp=80000000/1", b0.Rz, b0.ovf); else pass_cnt++;
    do_op(2'b11, 32'h5, lat, bc);
    total++; if (b0.Rz !== 32'hFFFFFFFB || b0.ovf !== 1'b0) $display("FAIL negabs_pos got=%h/%b exp=fffffffb/0", b0.Rz, b0.ovf); else pass_cnt++;
    do_op(2'b11, 32'hFFFFFFF0, lat, bc);
    total++; if (b0.Rz !== 32'hFFFFFFF0) $display("FAIL negabs_neg got=%h exp=fffffff0", b0.Rz); else pass_cnt++;
    do_op(2'b11, 32'h80000000, lat, bc);
    total++; if (b0.Rz !== 32'h80000000 || b0.ovf !== 1'b0) $display("FAIL negabs_mn got=%h/%b exp=80000000/0", b0.Rz, b0.ovf); else pass_cnt++;
    do_op(2'b00, 32'h12345678, lat, bc);
    total++; if (b0.Rz !== 32'h12345678 || b0.ovf !== 1'b0) $display("FAIL pass got=%h/%b exp=12345678/0", b0.Rz, b0.ovf); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk); b0.start = 1; b0.mode = 2'b01; b0.Ra = 32'h1;
    @(posedge clk); #1; b0.start = 0; b0.Ra = 32'h0;
    repeat (4) @(posedge clk); #1;
    total++; if (b0.done !== 1'b1 || b0.Rz !== 32'hFFFFFFFF) $display("FAIL b2b_first got=%b/%h exp=1/ffffffff", b0.done, b0.Rz); else pass_cnt++;
    b0.start = 1; b0.mode = 2'b01; b0.Ra = 32'h2;
    @(posedge clk); #1; b0.start = 0; b0.Ra = 32'h0;
    total++; if (b0.busy !== 1'b1 || b0.done !== 1'b0) $display("FAIL b2b_nodead got=%b/%b exp=1/0", b0.busy, b0.done); else pass_cnt++;
    lat = 0;
    while (!b0.done && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 4 || b0.Rz !== 32'hFFFFFFFE) $display("FAIL b2b_second got=%0d/%h exp=4/fffffffe", lat, b0.Rz); else pass_cnt++;
  endtask

  task automatic test_ignore;
    int lat;
    @(negedge clk); b0.start = 1; b0.mode = 2'b01; b0.Ra = 32'h10;
    @(posedge clk); #1; b0.start = 0;
    @(posedge clk); #1; b0.start = 1; b0.mode = 2'b00; b0.Ra = 32'h99;
    @(posedge clk); #1; b0.start = 0;
    lat = 2;
    while (!b0.done && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 4 || b0.Rz !== 32'hFFFFFFF0) $display("FAIL ignore_mid got=%0d/%h exp=4/fffffff0", lat, b0.Rz); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) $display("FAIL ignore_noqueue got=%b/%b exp=0/0", b0.busy, b0.done); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    do_op(2'b10, 32'h80000000, lat, bc);
    @(negedge clk); b0.start = 1; b0.mode = 2'b01; b0.Ra = 32'h3;
    @(posedge clk); #1; b0.start = 0;
    @(posedge clk); #1; clr_n = 0;
    @(posedge clk); #1; clr_n = 1;
    total++; if (b0.busy !== 1'b0 || b0.Rz !== 32'h0 || b0.ovf !== 1'b0) $display("FAIL rst_mid got=%b/%h/%b exp=0/00000000/0", b0.busy, b0.Rz, b0.ovf); else pass_cnt++;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (b0.done) seen = 1; end
    total++; if (seen !== 0) $display("FAIL rst_mid_nodone got=%0d exp=0", seen); else pass_cnt++;
    do_op(2'b01, 32'h3, lat, bc);
    total++; if (lat !== 4 || b0.Rz !== 32'hFFFFFFFD) $display("FAIL rst_mid_next got=%0d/%h exp=4/fffffffd", lat, b0.Rz); else pass_cnt++;
  endtask

  task automatic test_single;
    int lat;
    @(negedge clk); b1.start = 1; b1.mode = 2'b01; b1.Ra = 32'h1;
    @(posedge clk); #1; b1.start = 0; b1.Ra = 32'h0;
    total++; if (b1.busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", b1.busy); else pass_cnt++;
    lat = 0;
    while (!b1.done && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 1 || b1.Rz !== 32'hFFFFFFFF) $display("FAIL single got=%0d/%h exp=1/ffffffff", lat, b1.Rz); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_negate;
    test_modes;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
    test_single;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
